// File: rtl/eth_pfc_rxcontrol_if.sv
// Receive byte-stream bundle from RxEthMAC into the PFC control-frame decoder.
interface eth_pfc_rxcontrol_if;
    logic [7:0] RxData;
    logic       RxValid;
    logic       RxStartFrm;
    logic       RxEndFrm;
    logic       ReceiveEnd;
    logic       ReceivedPacketGood;

    modport master (
        output RxData, RxValid, RxStartFrm, RxEndFrm, ReceiveEnd, ReceivedPacketGood
    );
    modport slave (
        input  RxData, RxValid, RxStartFrm, RxEndFrm, ReceiveEnd, ReceivedPacketGood
    );
endinterface

// File: rtl/eth_pfc_rxcontrol.sv
// 802.1Qbb PFC receive decoder: parses MAC control frames and runs per-class pause timers.
// Optional 802.3x PAUSE acceptance is enabled by defining ETH_PFC_LEGACY_PAUSE_EN.
module eth_pfc_rxcontrol #(
    parameter int NUM_CLASSES = 8,
    parameter int TIMER_W     = 16,
    parameter int SLOT_CLKS   = 128
) (
    input  logic                   MRxClk,
    input  logic                   Reset,
    eth_pfc_rxcontrol_if.slave     rx,
    input  logic                   RxFlow,
    input  logic [47:0]            MAC,
    output logic [NUM_CLASSES-1:0] Paused,
    output logic                   ControlFrmAddressOK,
    output logic                   ReceivedPfcFrm,
    output logic                   SetPfcTimer
);
    localparam int MIN_LEN = 18 + 2 * NUM_CLASSES;
    localparam int PW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(SLOT_CLKS - 1);
    localparam logic [47:0] PFC_MC_DA = 48'h0180_C200_0001;

    logic [5:0]         byte_cnt;
    logic               in_frame;
    logic               byte_en;
    logic [5:0]         idx;
    logic               mc_miss, uc_miss, mc_ne, uc_ne, mc_prev, uc_prev;
    logic               type_hi_ok, type_lo_ok;
    logic [7:0]         op_hi;
    logic [NUM_CLASSES-1:0] shadow_en;
    logic [15:0]        shadow_time [NUM_CLASSES];
    logic [NUM_CLASSES-1:0] load_en;
    logic [TIMER_W-1:0] load_val [NUM_CLASSES];
    logic [TIMER_W-1:0] timer [NUM_CLASSES];
    logic [PW-1:0]      presc;
    logic               tick;
    logic               commit;
`ifdef ETH_PFC_LEGACY_PAUSE_EN
    logic               legacy_frm;
    logic [15:0]        legacy_time;
`endif

    function automatic logic [7:0] addr_byte(input logic [47:0] a, input logic [5:0] i);
        case (i)
            6'd0:    return a[47:40];
            6'd1:    return a[39:32];
            6'd2:    return a[31:24];
            6'd3:    return a[23:16];
            6'd4:    return a[15:8];
            6'd5:    return a[7:0];
            default: return '0;
        endcase
    endfunction

    // A start byte is byte 0 regardless of the counter, so a mid-frame restart reparses cleanly.
    always_comb begin
        byte_en = rx.RxValid && (rx.RxStartFrm || in_frame);
        idx     = rx.RxStartFrm ? '0 : byte_cnt;
        mc_ne   = rx.RxData != addr_byte(PFC_MC_DA, idx);
        uc_ne   = rx.RxData != addr_byte(MAC, idx);
        mc_prev = rx.RxStartFrm ? 1'b0 : mc_miss;
        uc_prev = rx.RxStartFrm ? 1'b0 : uc_miss;
    end

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            byte_cnt            <= '0;
            in_frame            <= 1'b0;
            mc_miss             <= 1'b0;
            uc_miss             <= 1'b0;
            type_hi_ok          <= 1'b0;
            type_lo_ok          <= 1'b0;
            op_hi               <= '0;
            shadow_en           <= '0;
            shadow_time         <= '{default: '0};
            ControlFrmAddressOK <= 1'b0;
            ReceivedPfcFrm      <= 1'b0;
`ifdef ETH_PFC_LEGACY_PAUSE_EN
            legacy_frm          <= 1'b0;
            legacy_time         <= '0;
`endif
        end else if (byte_en) begin
            if (rx.RxStartFrm) begin
                byte_cnt            <= 6'd1;
                type_hi_ok          <= 1'b0;
                type_lo_ok          <= 1'b0;
                op_hi               <= '0;
                shadow_en           <= '0;
                shadow_time         <= '{default: '0};
                ControlFrmAddressOK <= 1'b0;
                ReceivedPfcFrm      <= 1'b0;
`ifdef ETH_PFC_LEGACY_PAUSE_EN
                legacy_frm          <= 1'b0;
                legacy_time         <= '0;
`endif
            end else begin
                byte_cnt <= (byte_cnt == 6'd63) ? byte_cnt : byte_cnt + 6'd1;
            end
            in_frame <= !rx.RxEndFrm;
            if (idx < 6'd6) begin
                mc_miss <= mc_prev | mc_ne;
                uc_miss <= uc_prev | uc_ne;
            end
            if (idx == 6'd5)
                ControlFrmAddressOK <= !(mc_prev | mc_ne) || !(uc_prev | uc_ne);
            if (idx == 6'd12) type_hi_ok <= rx.RxData == 8'h88;
            if (idx == 6'd13) type_lo_ok <= rx.RxData == 8'h08;
            if (idx == 6'd14) op_hi <= rx.RxData;
            if (idx == 6'd15) begin
`ifdef ETH_PFC_LEGACY_PAUSE_EN
                legacy_frm     <= ControlFrmAddressOK && type_hi_ok && type_lo_ok &&
                                  op_hi == 8'h00 && rx.RxData == 8'h01;
                ReceivedPfcFrm <= ControlFrmAddressOK && type_hi_ok && type_lo_ok &&
                                  (op_hi == 8'h01 || op_hi == 8'h00) && rx.RxData == 8'h01;
`else
                ReceivedPfcFrm <= ControlFrmAddressOK && type_hi_ok && type_lo_ok &&
                                  op_hi == 8'h01 && rx.RxData == 8'h01;
`endif
            end
`ifdef ETH_PFC_LEGACY_PAUSE_EN
            if (idx == 6'd16) legacy_time[15:8] <= rx.RxData;
            if (idx == 6'd17) legacy_time[7:0]  <= rx.RxData;
`endif
            if (idx == 6'd17) shadow_en <= rx.RxData[NUM_CLASSES-1:0];
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                if (32'(idx) == 32'(18 + 2 * i)) shadow_time[i][15:8] <= rx.RxData;
                if (32'(idx) == 32'(19 + 2 * i)) shadow_time[i][7:0]  <= rx.RxData;
            end
        end
    end

    always_comb begin
        load_en = shadow_en;
        for (int unsigned i = 0; i < NUM_CLASSES; i++)
            load_val[i] = TIMER_W'(shadow_time[i]);
`ifdef ETH_PFC_LEGACY_PAUSE_EN
        if (legacy_frm) begin
            load_en = '1;
            for (int unsigned i = 0; i < NUM_CLASSES; i++)
                load_val[i] = TIMER_W'(legacy_time);
        end
`endif
    end

    assign tick   = presc == '0;
    assign commit = rx.ReceiveEnd && rx.ReceivedPacketGood && ReceivedPfcFrm && RxFlow &&
                    32'(byte_cnt) >= 32'(MIN_LEN);

    always_ff @(posedge MRxClk or posedge Reset) begin
        if (Reset) begin
            presc       <= '0;
            timer       <= '{default: '0};
            Paused      <= '0;
            SetPfcTimer <= 1'b0;
        end else begin
            SetPfcTimer <= commit;
            presc       <= (commit || tick) ? PRESC_TOP : presc - PW'(1);
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                Paused[i] <= timer[i] != '0;
                if (!RxFlow)
                    timer[i] <= '0;
                else if (commit && load_en[i])
                    timer[i] <= load_val[i];
                else if (tick && timer[i] != '0)
                    timer[i] <= timer[i] - TIMER_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_eth_pfc_rxcontrol.sv
// Directed bench for eth_pfc_rxcontrol with a release-time model of the pause timers.
module tb_eth_pfc_rxcontrol;
    localparam int NC   = 8;
    localparam int SLOT = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          RxFlow;
    logic [47:0]   MAC;
    logic [NC-1:0] Paused;
    logic          addr_ok, pfc_frm, set_t;

    always #5 clk = ~clk;

    eth_pfc_rxcontrol_if rx ();

    eth_pfc_rxcontrol #(.NUM_CLASSES(NC), .TIMER_W(16), .SLOT_CLKS(SLOT)) dut (
        .MRxClk             (clk),
        .Reset              (rst),
        .rx                 (rx),
        .RxFlow             (RxFlow),
        .MAC                (MAC),
        .Paused             (Paused),
        .ControlFrmAddressOK(addr_ok),
        .ReceivedPfcFrm     (pfc_frm),
        .SetPfcTimer        (set_t)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame under construction and what the model loads if it commits
    logic [7:0]    fq [$];
    logic [NC-1:0] frm_en;
    logic [15:0]   frm_time [NC];
    bit            frm_commit = 0;

    // Model: each class is paused until an absolute release edge
    longint        edge_n = 0;
    longint        release_e [NC];
    bit            nz [NC];
    logic [NC-1:0] paused_exp = '0;
    bit            set_exp = 0;
    bit            cmp_en = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            for (int i = 0; i < NC; i++) begin release_e[i] = 0; nz[i] = 0; end
            paused_exp = '0;
            set_exp = 0;
        end else begin
            for (int i = 0; i < NC; i++) paused_exp[i] = nz[i];
            set_exp = 0;
            if (!RxFlow) begin
                for (int i = 0; i < NC; i++) release_e[i] = edge_n;
            end else if (rx.ReceiveEnd && frm_commit) begin
                set_exp = 1;
                for (int i = 0; i < NC; i++) begin
                    if (frm_en[i])
                        release_e[i] = edge_n + longint'(SLOT) * longint'(frm_time[i]);
                    else if (release_e[i] > edge_n)
                        release_e[i] = edge_n + SLOT * ((release_e[i] - edge_n + SLOT - 1) / SLOT);
                end
            end
            for (int i = 0; i < NC; i++) nz[i] = release_e[i] > edge_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("paused_model", Paused, paused_exp);
            chk("set_pfc_timer_model", set_t, set_exp);
        end
    end

    task automatic build_frame(input logic [47:0] da, input logic [15:0] op, input logic [7:0] en);
        logic [15:0] t;
        fq.delete();
        for (int k = 0; k < 6; k++) fq.push_back(da[47 - 8 * k -: 8]);
        for (int k = 0; k < 6; k++) fq.push_back(8'h02 + 8'(k));
        fq.push_back(8'h88); fq.push_back(8'h08);
        fq.push_back(op[15:8]); fq.push_back(op[7:0]);
        if (op == 16'h0001) begin
            t = frm_time[0];
            fq.push_back(t[15:8]); fq.push_back(t[7:0]);
            for (int k = 0; k < 2 * NC; k++) fq.push_back(8'h00);
`ifdef ETH_PFC_LEGACY_PAUSE_EN
            frm_en = '1;
            for (int i = 0; i < NC; i++) frm_time[i] = t;
`endif
        end else begin
            fq.push_back(8'h00); fq.push_back(en);
            frm_en = en[NC-1:0];
            for (int i = 0; i < NC; i++) begin
                t = frm_time[i];
                fq.push_back(t[15:8]); fq.push_back(t[7:0]);
            end
        end
    endtask

    task automatic set_times(input logic [15:0] v);
        for (int i = 0; i < NC; i++) frm_time[i] = v;
    endtask

    task automatic feed(input int nbytes, input bit with_end);
        for (int k = 0; k < nbytes; k++) begin
            rx.RxValid = 1'b1; rx.RxData = fq[k];
            rx.RxStartFrm = (k == 0);
            rx.RxEndFrm = with_end && (k == nbytes - 1);
            @(posedge clk); #1;
        end
        rx.RxValid = 1'b0; rx.RxStartFrm = 1'b0; rx.RxEndFrm = 1'b0;
    endtask

    // Ends one time unit after the ReceiveEnd edge, where a commit would show SetPfcTimer
    task automatic send_frame(input int nbytes, input bit good, input bit exp_commit);
        feed(nbytes, 1'b1);
        @(posedge clk); #1;
        rx.ReceiveEnd = 1'b1; rx.ReceivedPacketGood = good; frm_commit = exp_commit;
        @(posedge clk); #1;
        rx.ReceiveEnd = 1'b0; rx.ReceivedPacketGood = 1'b0; frm_commit = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (Paused !== '0 && n < limit) begin @(posedge clk); #1; n++; end
        chk("wait_idle_timeout", Paused, 0);
        cycles(2);
    endtask

    int n, n2, n0;
    localparam logic [47:0] MC = 48'h0180_C200_0001;

    initial begin
        rx.RxData = '0; rx.RxValid = 0; rx.RxStartFrm = 0; rx.RxEndFrm = 0;
        rx.ReceiveEnd = 0; rx.ReceivedPacketGood = 0;
        RxFlow = 1'b1; MAC = 48'h0011_2233_4455;
        set_times(16'h0);
        cycles(3);
        chk("reset_paused", Paused, 0);
        chk("reset_addr_ok", addr_ok, 0);
        chk("reset_pfc_frm", pfc_frm, 0);
        chk("reset_set", set_t, 0);
        rst = 1'b0; cmp_en = 1;
        cycles(2);

        // Good PFC frame: class0=3 quanta, class2=1 quantum
        set_times(16'h0); frm_time[0] = 16'd3; frm_time[2] = 16'd1;
        build_frame(MC, 16'h0101, 8'h05);
        send_frame(34, 1'b1, 1'b1);
        chk("a_set_pulse", set_t, 1);
        chk("a_addr_ok", addr_ok, 1);
        chk("a_pfc_frm", pfc_frm, 1);
        cycles(1); n = 1;
        chk("a_paused", Paused, 8'h05);
        while (Paused[2] && n < 1000) begin cycles(1); n++; end
        n2 = n;
        while (Paused[0] && n < 1000) begin cycles(1); n++; end
        n0 = n;
        chk("a_class2_release_cycles", n2, 129);
        chk("a_class0_release_cycles", n0, 385);

        // Same frame with bad CRC
        send_frame(34, 1'b0, 1'b0);
        chk("b_set", set_t, 0);
        chk("b_addr_ok", addr_ok, 1);
        cycles(2);
        chk("b_paused", Paused, 0);

        // Unicast DA, all classes max, then release class0 with time 0
        set_times(16'hFFFF);
        build_frame(MAC, 16'h0101, 8'hFF);
        send_frame(34, 1'b1, 1'b1);
        cycles(1);
        chk("c_addr_ok", addr_ok, 1);
        chk("c_paused_ff", Paused, 8'hFF);
        set_times(16'h0);
        build_frame(MAC, 16'h0101, 8'h01);
        send_frame(34, 1'b1, 1'b1);
        cycles(1);
        chk("c_paused_fe", Paused, 8'hFE);
        RxFlow = 1'b0; cycles(2);
        chk("c_flow_clear", Paused, 0);
        RxFlow = 1'b1; cycles(2);

        // Class0 timer 10, truncated frame, then flow-off without restoration
        set_times(16'h0); frm_time[0] = 16'd10;
        build_frame(MC, 16'h0101, 8'h01);
        send_frame(34, 1'b1, 1'b1);
        set_times(16'hFFFF);
        build_frame(MC, 16'h0101, 8'hFF);
        send_frame(26, 1'b1, 1'b0);
        chk("d_trunc_set", set_t, 0);
        chk("d_trunc_pfc_frm", pfc_frm, 1);
        cycles(1);
        chk("d_trunc_paused", Paused, 8'h01);
        RxFlow = 1'b0; cycles(2);
        chk("e_flow_off", Paused, 0);
        RxFlow = 1'b1; cycles(5);
        chk("e_no_restore", Paused, 0);

        // 802.3x PAUSE opcode, time 2
        set_times(16'h0); frm_time[0] = 16'd2;
        build_frame(MC, 16'h0001, 8'h00);
`ifdef ETH_PFC_LEGACY_PAUSE_EN
        send_frame(34, 1'b1, 1'b1);
        chk("f_legacy_pfc_frm", pfc_frm, 1);
        cycles(1);
        chk("f_legacy_paused", Paused, 8'hFF);
`else
        send_frame(34, 1'b1, 1'b0);
        chk("f_legacy_pfc_frm", pfc_frm, 0);
        cycles(1);
        chk("f_legacy_paused", Paused, 8'h00);
`endif
        wait_idle(600);

        // Address matches neither candidate
        set_times(16'd4);
        build_frame(48'h0A0B_0C0D_0E0F, 16'h0101, 8'hFF);
        send_frame(34, 1'b1, 1'b0);
        chk("g_addr_ok", addr_ok, 0);
        chk("g_pfc_frm", pfc_frm, 0);

        // Commit for class1 while class0 is mid-pause: class0 keeps counting on the new phase
        set_times(16'h0); frm_time[0] = 16'd3;
        build_frame(MC, 16'h0101, 8'h01);
        send_frame(34, 1'b1, 1'b1);
        cycles(200);
        set_times(16'h0); frm_time[1] = 16'd1;
        build_frame(MC, 16'h0101, 8'h02);
        send_frame(34, 1'b1, 1'b1);
        cycles(1);
        chk("h_paused_both", Paused, 8'h03);
        wait_idle(800);

        // Restart mid-frame, then a complete frame commits normally
        set_times(16'h7);
        build_frame(MAC, 16'h0101, 8'hFF);
        feed(30, 1'b0);
        set_times(16'h0); frm_time[3] = 16'd2;
        build_frame(MC, 16'h0101, 8'h08);
        send_frame(34, 1'b1, 1'b1);
        chk("i_restart_set", set_t, 1);
        cycles(1);
        chk("i_restart_paused", Paused, 8'h08);
        wait_idle(600);

        // Reset mid-pause, then normal parsing
        set_times(16'd5);
        build_frame(MC, 16'h0101, 8'h03);
        send_frame(34, 1'b1, 1'b1);
        cycles(20);
        rst = 1'b1; #1;
        chk("j_reset_paused", Paused, 0);
        chk("j_reset_addr_ok", addr_ok, 0);
        cycles(2);
        rst = 1'b0; cycles(2);
        set_times(16'h0); frm_time[0] = 16'd1;
        build_frame(MC, 16'h0101, 8'h01);
        send_frame(34, 1'b1, 1'b1);
        cycles(1);
        chk("j_after_reset_paused", Paused, 8'h01);
        wait_idle(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
